// File: rtl/fifo_lifo_ctrl.sv
// Address/enable sequencer that runs a dual-port synchronous ram as a FIFO queue or a LIFO stack.
// Carries control only; data flows directly between producer, ram and consumer.
module fifo_lifo_ctrl #(
  parameter int unsigned dat_width = 32,
  parameter int unsigned adr_width = 6,
  parameter int unsigned mem_size  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [adr_width-1:0] ram_adr_wr_o,
  output logic [adr_width-1:0] ram_adr_rd_o,
  output logic                 ram_we_o,
  output logic                 ram_rde_o,
  output logic                 rd_valid_o,
  output logic [adr_width:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 mode_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  if (mem_size < 2 || mem_size > (1 << adr_width) || dat_width == 0) begin : g_bad_params
    $error("fifo_lifo_ctrl: illegal parameter combination");
  end

  localparam logic [adr_width:0]   MemSize = (adr_width + 1)'(mem_size);
  localparam logic [adr_width-1:0] LastAdr = adr_width'(mem_size - 1);

  logic [adr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [adr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [adr_width:0]   count_q, count_d;
  logic                 mode_q, mode_d;
  logic                 rd_valid_q;
  logic                 overflow_q, underflow_q;

  logic                 full, empty;
  logic                 push_acc, pop_acc;
  logic                 overflow_d, underflow_d;
  logic [adr_width-1:0] lifo_top, lifo_next;

  // Flags decode from the count register only, keeping push/pop off the flag timing paths.
  assign full  = (count_q == MemSize);
  assign empty = (count_q == '0);

  assign pop_acc  = pop_i & ~empty & ~flush_i;
  assign push_acc = push_i & ~flush_i & (~full | pop_acc);

  assign overflow_d  = push_i & ~flush_i & ~push_acc;
  assign underflow_d = pop_i & ~flush_i & empty;

  // count never exceeds 2^adr_width, so the low bits are the stack slot above the top.
  assign lifo_next = count_q[adr_width-1:0];
  assign lifo_top  = lifo_next - adr_width'(1);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_acc && !pop_acc) begin
      count_d = count_q + (adr_width + 1)'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - (adr_width + 1)'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (!mode_q) begin
      if (push_acc) begin
        wr_ptr_d = (wr_ptr_q == LastAdr) ? '0 : wr_ptr_q + adr_width'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = (rd_ptr_q == LastAdr) ? '0 : rd_ptr_q + adr_width'(1);
      end
    end
  end

  // Mode may only change once the block is (or is about to be) empty; flush falls out of this.
  always_comb begin
    mode_d = mode_q;
    if (count_d == '0 && !push_acc) begin
      mode_d = mode_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      rd_valid_q  <= pop_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // LIFO push+pop overwrites the current top after the ram has read it out.
  assign ram_adr_wr_o = mode_q ? (pop_acc ? lifo_top : lifo_next) : wr_ptr_q;
  assign ram_adr_rd_o = mode_q ? lifo_top : rd_ptr_q;
  assign ram_we_o     = push_acc;
  assign ram_rde_o    = pop_acc;

  assign rd_valid_o  = rd_valid_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign mode_o      = mode_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_lifo_ctrl.sv
// Directed bench for fifo_lifo_ctrl with a behavioural read-before-write dual-port ram attached.
module tb_fifo_lifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, push, pop, flush;
  logic [31:0] din, dout;
  logic [5:0]  adr_wr, adr_rd;
  logic        we, rde, rd_valid, full, empty, mode_act, ovf, unf;
  logic [6:0]  count;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_lifo_ctrl #(
    .dat_width(32),
    .adr_width(6),
    .mem_size (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .ram_adr_wr_o(adr_wr),
    .ram_adr_rd_o(adr_rd),
    .ram_we_o    (we),
    .ram_rde_o   (rde),
    .rd_valid_o  (rd_valid),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .mode_o      (mode_act),
    .overflow_o  (ovf),
    .underflow_o (unf)
  );

  // Companion ram: registered read, old data returned on a same-address write.
  always @(posedge clk) begin
    if (we) mem[adr_wr] <= din;
    if (rde) dout <= mem[adr_rd];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [31:0] d);
    push = p;
    pop  = q;
    din  = d;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " full"}, 32'(full), 32'd0);
    check({tag, " mode"}, 32'(mode_act), 32'd0);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, " overflow"}, 32'(ovf), 32'd0);
    check({tag, " underflow"}, 32'(unf), 32'd0);
    check({tag, " we"}, 32'(we), 32'd0);
    check({tag, " rde"}, 32'(rde), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // FIFO fill, overflow, drain.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 32'(i));
      check($sformatf("fill adr_wr %0d", i), 32'(adr_wr), 32'(i));
      tick();
    end
    check("fill count", 32'(count), 32'd64);
    check("fill full", 32'(full), 32'd1);
    drive(1'b1, 1'b0, 32'd99);
    check("overflow we", 32'(we), 32'd0);
    tick();
    check("overflow pulse", 32'(ovf), 32'd1);
    check("overflow count", 32'(count), 32'd64);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("overflow one cycle", 32'(ovf), 32'd0);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
      check($sformatf("drain valid %0d", i), 32'(rd_valid), 32'd1);
      check($sformatf("drain data %0d", i), dout, 32'(i));
    end
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("drain valid off", 32'(rd_valid), 32'd0);
    check("drain empty", 32'(empty), 32'd1);

    // FIFO wrap.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 32'(100 + i));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
      check($sformatf("wrap pop1 %0d", i), dout, 32'(100 + i));
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 32'(200 + i));
      check($sformatf("wrap adr_wr %0d", i), 32'(adr_wr), 32'((40 + i) % 64));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
      check($sformatf("wrap pop2 %0d", i), dout, 32'(200 + i));
    end

    // FIFO full with push+pop returns the oldest entry.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 32'(300 + i));
      tick();
    end
    drive(1'b1, 1'b1, 32'd999);
    check("full pp we", 32'(we), 32'd1);
    check("full pp rde", 32'(rde), 32'd1);
    check("full pp same adr", 32'(adr_wr), 32'(adr_rd));
    tick();
    check("full pp count", 32'(count), 32'd64);
    check("full pp data", dout, 32'd300);
    check("full pp overflow", 32'(ovf), 32'd0);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
      check($sformatf("full pp drain %0d", i), dout, (i == 63) ? 32'd999 : 32'(301 + i));
    end
    drive(1'b0, 1'b0, 32'd0);

    // LIFO order and underflow.
    mode = 1'b1;
    tick();
    check("lifo mode", 32'(mode_act), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'(i + 1));
      check($sformatf("lifo adr_wr %0d", i), 32'(adr_wr), 32'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      check($sformatf("lifo adr_rd %0d", i), 32'(adr_rd), 32'(2 - i));
      tick();
      check($sformatf("lifo data %0d", i), dout, 32'(3 - i));
    end
    drive(1'b0, 1'b1, 32'd0);
    check("lifo underflow rde", 32'(rde), 32'd0);
    tick();
    check("lifo underflow pulse", 32'(unf), 32'd1);
    check("lifo underflow valid", 32'(rd_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("lifo underflow one cycle", 32'(unf), 32'd0);

    // LIFO push+pop replaces the top.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(10 + i));
      tick();
    end
    drive(1'b1, 1'b1, 32'd77);
    check("lifo pp adr_wr", 32'(adr_wr), 32'd4);
    check("lifo pp adr_rd", 32'(adr_rd), 32'd4);
    tick();
    check("lifo pp count", 32'(count), 32'd5);
    check("lifo pp old top", dout, 32'd14);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
      check($sformatf("lifo pp pop %0d", i), dout, (i == 0) ? 32'd77 : 32'(14 - i));
    end

    // Push+pop on empty: pop rejected, push kept.
    drive(1'b1, 1'b1, 32'd55);
    check("empty pp rde", 32'(rde), 32'd0);
    check("empty pp we", 32'(we), 32'd1);
    tick();
    check("empty pp underflow", 32'(unf), 32'd1);
    check("empty pp count", 32'(count), 32'd1);
    check("empty pp valid", 32'(rd_valid), 32'd0);
    drive(1'b0, 1'b1, 32'd0);
    tick();
    check("empty pp data", dout, 32'd55);

    // Mode lock while non-empty.
    drive(1'b0, 1'b0, 32'd0);
    mode = 1'b0;
    tick();
    check("lock fifo mode", 32'(mode_act), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'(600 + i));
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
    mode = 1'b1;
    tick();
    check("lock held", 32'(mode_act), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
      check($sformatf("lock data %0d", i), dout, 32'(600 + i));
      check($sformatf("lock mode %0d", i), 32'(mode_act), (i == 2) ? 32'd1 : 32'd0);
    end

    // Pop followed by flush: data still valid, then cleared.
    drive(1'b0, 1'b0, 32'd0);
    mode = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'(400 + i));
      tick();
    end
    drive(1'b0, 1'b1, 32'd0);
    tick();
    flush = 1'b1;
    mode  = 1'b1;
    drive(1'b1, 1'b1, 32'd0);
    check("flush valid", 32'(rd_valid), 32'd1);
    check("flush data", dout, 32'd400);
    check("flush we", 32'(we), 32'd0);
    check("flush rde", 32'(rde), 32'd0);
    tick();
    check("flush count", 32'(count), 32'd0);
    check("flush empty", 32'(empty), 32'd1);
    check("flush valid off", 32'(rd_valid), 32'd0);
    check("flush mode reload", 32'(mode_act), 32'd1);
    check("flush no overflow", 32'(ovf), 32'd0);
    flush = 1'b0;
    mode  = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'd500);
    check("flush ptr cleared", 32'(adr_wr), 32'd0);
    tick();

    // Reset mid-operation.
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'(500 + i));
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
    check("pre-reset count", 32'(count), 32'd10);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid reset");
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
